// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: reset/handler vectors,
// instruction-memory window, exception codes and next-PC select encodings.
package pc_fetch_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned EXC_W  = 5;

  localparam logic [ADDR_W-1:0] PC_RESET   = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] PC_HANDLER = 32'h0000_4180;
  localparam logic [ADDR_W-1:0] PC_STEP    = 32'h0000_0004;

  // Inclusive bounds of the word-aligned instruction memory window.
  localparam logic [ADDR_W-1:0] IM_LO = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] IM_HI = 32'h0000_6FFC;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_AdEL = 5'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  function automatic logic fetch_addr_fault(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_mux.sv
// Combinational next-PC selection; priority req > stall > eret > npc_sel.
// Reset is applied at the PC register itself, not here.
module npc_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              req_i,
  input  logic              stall_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  npc_sel_e          npc_sel_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic [ADDR_W-1:0] j_target_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] npc_o
);

  logic [ADDR_W-1:0] flow_npc;
  logic [ADDR_W-1:0] seq_npc;

  // Plain 32-bit add: wraps past 0xFFFF_FFFC with the carry discarded.
  assign seq_npc = pc_i + PC_STEP;

  always_comb begin
    flow_npc = seq_npc;
    unique case (npc_sel_i)
      NPC_SEQ: flow_npc = seq_npc;
      NPC_BR:  flow_npc = br_target_i;
      NPC_J:   flow_npc = j_target_i;
      NPC_JR:  flow_npc = jr_target_i;
    endcase
  end

  always_comb begin
    npc_o = flow_npc;
    if (req_i) begin
      npc_o = PC_HANDLER;
    end else if (stall_i) begin
      npc_o = pc_i;
    end else if (eret_i) begin
      npc_o = epc_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, instruction-address fault detection and gating
// of the fetched instruction / exception code / delay-slot flag.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              eret_d,
  input  logic [ADDR_W-1:0] epc,
  input  logic [1:0]        npc_sel,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              is_bj_d,
  output logic [ADDR_W-1:0] i_inst_addr,
  input  logic [ADDR_W-1:0] i_inst_rdata,
  output logic [ADDR_W-1:0] pc_f,
  output logic [ADDR_W-1:0] instr_f,
  output logic [EXC_W-1:0]  exc_code_f,
  output logic              bd_f
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              adel;

  npc_mux u_npc_mux (
    .pc_i        (pc_q),
    .req_i       (req),
    .stall_i     (stall),
    .eret_i      (eret_d),
    .epc_i       (epc),
    .npc_sel_i   (npc_sel_e'(npc_sel)),
    .br_target_i (br_target),
    .j_target_i  (j_target),
    .jr_target_i (jr_target),
    .npc_o       (pc_d)
  );

  // The PC is the only state in the fetch stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_f        = pc_q;
  assign i_inst_addr = pc_q;
  assign adel        = fetch_addr_fault(pc_q);

  // An eret in D squashes whatever was fetched behind it, fault or not.
  always_comb begin
    instr_f    = i_inst_rdata;
    exc_code_f = EXC_NONE;
    bd_f       = is_bj_d;
    if (eret_d) begin
      instr_f    = '0;
      exc_code_f = EXC_NONE;
      bd_f       = 1'b0;
    end else if (adel) begin
      instr_f    = '0;
      exc_code_f = EXC_AdEL;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// cycles compared against a behavioural fetch-stage model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, req, stall, eret_d, is_bj_d;
  logic [31:0] epc, br_target, j_target, jr_target, i_inst_rdata;
  logic [1:0]  npc_sel;
  logic [31:0] i_inst_addr, pc_f, instr_f;
  logic [4:0]  exc_code_f;
  logic        bd_f;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .stall        (stall),
    .eret_d       (eret_d),
    .epc          (epc),
    .npc_sel      (npc_sel),
    .br_target    (br_target),
    .j_target     (j_target),
    .jr_target    (jr_target),
    .is_bj_d      (is_bj_d),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .pc_f         (pc_f),
    .instr_f      (instr_f),
    .exc_code_f   (exc_code_f),
    .bd_f         (bd_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next();
    if (reset)       return 32'h3000;
    if (req)         return 32'h4180;
    if (stall)       return m_pc;
    if (eret_d)      return epc;
    case (npc_sel)
      2'd0:    return m_pc + 32'd4;
      2'd1:    return br_target;
      2'd2:    return j_target;
      default: return jr_target;
    endcase
  endfunction

  function automatic logic model_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] e_instr;
    logic [31:0] e_exc;
    logic [31:0] e_bd;
    e_instr = i_inst_rdata;
    e_exc   = 0;
    e_bd    = {31'd0, is_bj_d};
    if (eret_d) begin
      e_instr = 0;
      e_bd    = 0;
    end else if (model_fault(m_pc)) begin
      e_instr = 0;
      e_exc   = 4;
    end
    check({tag, ".pc"},    pc_f, m_pc);
    check({tag, ".iaddr"}, i_inst_addr, m_pc);
    check({tag, ".instr"}, instr_f, e_instr);
    check({tag, ".exc"},   {27'd0, exc_code_f}, e_exc);
    check({tag, ".bd"},    {31'd0, bd_f}, e_bd);
  endtask

  task automatic set_idle();
    reset = 0; req = 0; stall = 0; eret_d = 0; is_bj_d = 0;
    npc_sel = 2'd0;
    epc = 32'h0; br_target = 32'h0; j_target = 32'h0; jr_target = 32'h0;
    i_inst_rdata = $urandom;
  endtask

  // Inputs are already applied; settle, check, then advance one clock.
  task automatic cycle(input string tag, input bit do_check);
    logic [31:0] nxt;
    #2;
    if (do_check) check_outputs(tag);
    nxt = model_next();
    @(posedge clk);
    #1;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0:       return 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      1:       return 32'h3000 + $urandom_range(0, 32'h3FFF);
      2:       return $urandom;
      3:       return 32'h6FFC;
      4:       return 32'h2FFC;
      default: return 32'h3000 + ($urandom_range(0, 16) << 2);
    endcase
  endfunction

  initial begin
    m_pc = 32'h0;
    set_idle();
    @(posedge clk);
    #1;
    reset = 1;
    cycle("rst", 1'b0);
    set_idle();

    // Sequential fetch after reset.
    check("r35.pc0", pc_f, 32'h3000);
    check("r35.exc0", {27'd0, exc_code_f}, 32'd0);
    #2 check("r35.instr0", instr_f, i_inst_rdata);
    cycle("r35a", 1'b1); check("r35.pc1", pc_f, 32'h3004);
    cycle("r35b", 1'b1); check("r35.pc2", pc_f, 32'h3008);
    cycle("r35c", 1'b1); check("r35.pc3", pc_f, 32'h300C);
    cycle("r35d", 1'b1); check("r36.pc", pc_f, 32'h3010);

    // Two stall cycles hold the PC.
    stall = 1; cycle("r36a", 1'b1); check("r36.hold1", pc_f, 32'h3010);
    cycle("r36b", 1'b1); check("r36.hold2", pc_f, 32'h3010);
    stall = 0; cycle("r36c", 1'b1); check("r36.next", pc_f, 32'h3014);

    // Misaligned jr target loads unchanged and faults on the next fetch.
    npc_sel = 2'd3; jr_target = 32'h3002;
    cycle("r37a", 1'b1); set_idle();
    #2;
    check("r37.pc", pc_f, 32'h3002);
    check("r37.exc", {27'd0, exc_code_f}, 32'd4);
    check("r37.instr", instr_f, 32'd0);
    npc_sel = 2'd3; jr_target = 32'h3002; stall = 1; req = 1;
    cycle("r37b", 1'b1); set_idle();
    check("r37.req", pc_f, 32'h4180);

    // eret squashes the fetch slot and redirects to epc.
    eret_d = 1; epc = 32'h3040; is_bj_d = 1;
    #2;
    check("r38.instr", instr_f, 32'd0);
    check("r38.bd", {31'd0, bd_f}, 32'd0);
    check("r38.exc", {27'd0, exc_code_f}, 32'd0);
    cycle("r38a", 1'b1); set_idle();
    check("r38.pc", pc_f, 32'h3040);

    // req beats eret in the same cycle.
    req = 1; eret_d = 1; epc = 32'h3100;
    cycle("r29", 1'b1); set_idle();
    check("r29.pc", pc_f, 32'h4180);

    // Upper boundary of the instruction window.
    npc_sel = 2'd2; j_target = 32'h6FFC;
    cycle("r39a", 1'b1); set_idle();
    #2;
    check("r39.pc", pc_f, 32'h6FFC);
    check("r39.exc_lo", {27'd0, exc_code_f}, 32'd0);
    cycle("r39b", 1'b1);
    check("r39.pc2", pc_f, 32'h7000);
    check("r39.exc_hi", {27'd0, exc_code_f}, 32'd4);

    // Sequential wrap at the top of the address space.
    npc_sel = 2'd1; br_target = 32'hFFFF_FFFC;
    cycle("wrapa", 1'b1); set_idle();
    cycle("wrapb", 1'b1);
    check("wrap.pc", pc_f, 32'h0000_0000);

    // Reset overrides req and stall.
    reset = 1; req = 1; stall = 1;
    cycle("r40", 1'b1); set_idle();
    check("r40.pc", pc_f, 32'h3000);

    // Randomized cycles against the model.
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      req          = ($urandom_range(0, 15) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      eret_d       = ($urandom_range(0, 9) == 0);
      is_bj_d      = $urandom_range(0, 1);
      npc_sel      = 2'($urandom_range(0, 3));
      epc          = rand_target();
      br_target    = rand_target();
      j_target     = rand_target();
      jr_target    = rand_target();
      i_inst_rdata = $urandom;
      cycle("rnd", 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req  in  1  exception/interrupt taken this cycle; redirect fetch to handler.
REQ-004 stall  in  1  hold current PC; F-stage outputs unchanged.
REQ-005 eret_d  in  1  eret resident in D stage; redirect fetch to epc.
REQ-006 epc  in  32  exception return address from CP0.
REQ-007 npc_sel  in  2  0 sequential, 1 branch taken, 2 jump immediate, 3 jump register.
REQ-008 br_target  in  32  branch target computed in D.
REQ-009 j_target  in  32  j/jal target computed in D.
REQ-010 jr_target  in  32  jr/jalr target, forwarded register value.
REQ-011 is_bj_d  in  1  instruction in D is a branch or jump.
REQ-012 i_inst_addr  out  32  instruction memory address, equal to pc_f.
REQ-013 i_inst_rdata  in  32  instruction memory read data, combinational, same cycle.
REQ-014 pc_f  out  32  current fetch PC, feeds IF/ID register.
REQ-015 instr_f  out  32  fetched instruction, or 0 when suppressed.
REQ-016 exc_code_f  out  5  fetch exception code; 0 none, 4 AdEL.
REQ-017 bd_f  out  1  fetched instruction sits in a branch delay slot.

Function
REQ-018 PC register SHALL update once per clock, selected by fixed priority: reset > req > stall > eret_d > npc_sel.
REQ-019 On req the next PC SHALL be 0x0000_4180, regardless of stall, eret_d or npc_sel.
REQ-020 On stall without req the PC SHALL hold its current value.
REQ-021 On eret_d without stall or req the next PC SHALL be epc.
REQ-022 npc_sel selects the next PC as: 0 → pc_f+4 (32-bit wrap, no carry-out); 1 → br_target; 2 → j_target; 3 → jr_target.
REQ-023 i_inst_addr SHALL equal pc_f, with zero latency.
REQ-024 AdEL SHALL be flagged when pc_f[1:0]≠0, pc_f<0x0000_3000, or pc_f>0x0000_6FFC. Boundary values 0x3000 and 0x6FFC SHALL NOT flag.
REQ-025 On AdEL: exc_code_f=4 and instr_f=0. Otherwise exc_code_f=0 and instr_f=i_inst_rdata.
REQ-026 When eret_d is high, instr_f SHALL be forced to 0, exc_code_f to 0 and bd_f to 0. Instructions after eret are never executed.
REQ-027 bd_f SHALL equal is_bj_d, combinationally, when eret_d is low.
REQ-028 A misaligned jr_target SHALL be loaded into the PC unchanged. The fault is reported on the following fetch cycle via REQ-024.
REQ-029 req and eret_d high in the same cycle: req wins and the next PC is 0x4180.

Reset
REQ-030 Reset SHALL set the PC to 0x0000_3000 on the next rising edge, overriding all other inputs, including a reset asserted mid-stall or mid-redirect.
REQ-031 After reset, outputs SHALL be pc_f=0x3000, exc_code_f=0 and instr_f=i_inst_rdata.
REQ-032 There SHALL be no state other than the PC register.

Structure
REQ-033 A shared package SHALL hold the constants PC_RESET=0x3000, PC_HANDLER=0x4180, IM_LO=0x3000, IM_HI=0x6FFC, EXC_AdEL=4, and the npc_sel encodings.
REQ-034 Next-PC selection SHALL be one sub-module, npc_mux (combinational). pc_fetch SHALL hold the PC register, AdEL detection and output gating.

Verification
REQ-035 Reset then 3 idle cycles with npc_sel=0 → pc_f sequence 0x3000, 0x3004, 0x3008, 0x300C.
REQ-036 stall high 2 cycles at pc_f=0x3010 → pc_f stays 0x3010 for both cycles, then 0x3014.
REQ-037 npc_sel=3 with jr_target=0x3002 → next cycle pc_f=0x3002, exc_code_f=4, instr_f=0; same case with stall=1 and req=1 → next pc_f=0x4180.
REQ-038 eret_d=1, epc=0x3040, is_bj_d=1 → same cycle instr_f=0, bd_f=0; next cycle pc_f=0x3040.
REQ-039 pc_f=0x6FFC with npc_sel=0 → exc_code_f=0 at 0x6FFC, then exc_code_f=4 at 0x7000.
REQ-040 reset asserted together with req=1 and stall=1 → next pc_f=0x3000.
